timer_bank: RTL and testbench
=============================

# timer_bank

Multi-channel programmable interval timer bank on the CPU's bridge bus. It generates the hardware interrupt lines that feed the CPU's `HWInt[7:2]` input. It generalises a single fixed timer in three ways:
- channel count and counter width are parameters;
- each channel has a selectable one-shot or auto-reload mode;
- each channel has a per-channel clock prescaler and a maskable, write-one-to-clear pending flag.

## Interface
- `CHANNELS`, default 2: number of timer channels, 1..6 (maps onto `HWInt[2+i]`).
- `WIDTH`, default 32: counter/preset width, 8..32. Register bits `[31:WIDTH]` read 0 and ignore writes.
- `BASE_ADDR`, default 32'h0000_7F00: byte address of channel 0. Channel i sits at `BASE_ADDR + 16*i`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high. Clears all state.
- `addr` in 32: bridge byte address. `addr[1:0]` is ignored.
- `wdata` in 32: write data.
- `we` in 4: per-byte write enables; bit b covers `wdata[8b+7:8b]`.
- `rdata` out 32: combinational read data for `addr`; 0 on miss.
- `irq` out CHANNELS: `irq[i] = PEND_i & IM_i`.

## Operation
- Per-channel registers, at the channel base offset:
  - +0 `CTRL`:
    - `[0]` EN;
    - `[2:1]` MODE: 00 one-shot, 01 auto-reload, 1x treated as one-shot;
    - `[3]` IM;
    - `[4]` PEND, read-only, W1C;
    - `[15:8]` PRESC.
    - Other bits read 0.
  - +4 `PRESET`: read/write.
  - +8 `COUNT`: read-only; writes are ignored.
  - +12 is unmapped and reads 0.
- Byte-enable writes merge only the enabled bytes. Writes with `we == 0` have no effect.
- Per-channel FSM states: IDLE, LOAD, COUNT, INT.
  - IDLE: leaves when EN=1 (checked after a write) and goes to LOAD.
  - LOAD: COUNT ← PRESET, prescaler ← 0, go to COUNT.
  - COUNT:
    - if COUNT==0, go to INT;
    - otherwise decrement on each tick.
    - A tick occurs when prescaler == PRESC. The prescaler then wraps to 0; otherwise it increments.
  - INT: PEND ← 1.
    - Auto-reload: go to LOAD.
    - One-shot: EN ← 0, go to IDLE.
- Clearing EN in any state forces IDLE on the next edge. COUNT holds its value.
- Writing PRESET during COUNT takes effect only at the next LOAD.
- PRESET = 0: LOAD → COUNT → INT with no decrements.
- Simultaneous events:
  - A hardware PEND set beats a software W1C in the same cycle, so PEND stays 1.
  - A software EN=0 write in the same cycle as an INT-state EN clear leaves EN=0.
  - A software EN=1 write while in INT in one-shot mode: the write wins. EN stays 1 and the FSM re-enters LOAD through IDLE.
- Reset (including mid-count): every register, FSM state and prescaler is cleared to 0/IDLE. `irq` = 0 and `rdata` reflects the zeroed registers.

## Timing
- Register writes land on the edge where `we != 0`.
- An EN=1 write at edge k gives:
  - LOAD after edge k;
  - COUNT=P after edge k+1.
- With PRESC=0, COUNT reaches 0 after edge k+1+P.
- INT and PEND=1 after edge k+2+P. `irq` asserts in the same cycle if IM=1.
- With PRESC=s, each decrement takes s+1 cycles, so PEND sets after edge k+2+P·(s+1).
- Auto-reload period is P·(s+1)+3 cycles between successive INT states.
- `rdata` is purely combinational. A read in the same cycle as a write returns the pre-write value.
- `irq` is registered-state derived only, with no combinational path from `wdata`.

## Test plan
- Reset mid-count:
  - Stimulus: CH0 PRESET=5, EN=1, then assert `reset` 3 cycles later.
  - Required: every register reads 0, `irq`=0, and the FSM does not restart after reset is released.
- One-shot:
  - Stimulus: PRESET=4, CTRL=0x09 (EN, IM, one-shot) written at edge k.
  - Required: COUNT reads 4,3,2,1,0 on successive cycles, `irq[0]`=1 after edge k+6, and EN reads 0 after edge k+7.
  - Required: a W1C write of 0x10 then drops `irq[0]`.
- Auto-reload with prescaler:
  - Stimulus: PRESET=2, PRESC=1, MODE=01.
  - Required: INT recurs every 7 cycles; PEND set-vs-clear collision keeps PEND=1.
- Byte-enable and width:
  - Stimulus: `WIDTH`=16; write 0xAABBCCDD to PRESET with `we`=4'b0011.
  - Required: PRESET reads 0x0000CCDD. A write to COUNT and to offset +12 changes nothing.
- Multi-channel and masking:
  - Stimulus: `CHANNELS`=3, all channels enabled with different presets, IM=0 on channel 1.
  - Required: `irq` asserts only bits 0 and 2 at their computed edges, while PEND_1 reads 1.
  - Required: an address outside the bank returns `rdata`=0.

Source files
------------

// File: rtl/timer_bank.sv
// rtl/timer_bank.sv - multi-channel programmable interval timer bank on the bridge bus
// Each channel: IDLE/LOAD/COUNT/INT FSM, clock prescaler, maskable W1C pending flag.
module timer_bank #(
  parameter int          CHANNELS  = 2,
  parameter int          WIDTH     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         addr,
  input  logic [31:0]         wdata,
  input  logic [3:0]          we,
  output logic [31:0]         rdata,
  output logic [CHANNELS-1:0] irq
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COUNT, S_INT} state_e;

  logic [CHANNELS-1:0][31:0] rd_ch;
  logic [1:0]                unused_addr;

  assign unused_addr = addr[1:0];

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    localparam logic [31:0] CH_BASE = BASE_ADDR + 32'(16 * i);

    state_e           state_q, state_d;
    logic             en_q, en_d, im_q, im_d, pend_q, pend_d, pend_set;
    logic [1:0]       mode_q, mode_d;
    logic [7:0]       presc_q, presc_d, pcnt_q, pcnt_d;
    logic [WIDTH-1:0] preset_q, preset_d, count_q, count_d;
    logic             hit, wr_ctrl, wr_preset;
    logic [31:0]      ctrl_rd;

    assign hit       = (addr[31:4] == CH_BASE[31:4]);
    assign wr_ctrl   = hit && (addr[3:2] == 2'd0) && (we != 4'd0);
    assign wr_preset = hit && (addr[3:2] == 2'd1) && (we != 4'd0);
    assign ctrl_rd   = {16'd0, presc_q, 3'd0, pend_q, im_q, mode_q, en_q};
    assign irq[i]    = pend_q & im_q;
    assign rd_ch[i]  = !hit                ? 32'd0 :
                       (addr[3:2] == 2'd0) ? ctrl_rd :
                       (addr[3:2] == 2'd1) ? 32'(preset_q) :
                       (addr[3:2] == 2'd2) ? 32'(count_q) : 32'd0;

    always_comb begin
      en_d     = en_q;
      mode_d   = mode_q;
      im_d     = im_q;
      presc_d  = presc_q;
      preset_d = preset_q;
      pend_d   = pend_q;
      state_d  = state_q;
      count_d  = count_q;
      pcnt_d   = pcnt_q;
      pend_set = 1'b0;

      // A software EN write in the same cycle overrides the one-shot self-clear
      if (state_q == S_INT && mode_q != 2'b01) en_d = 1'b0;
      if (wr_ctrl && we[0]) begin
        en_d   = wdata[0];
        mode_d = wdata[2:1];
        im_d   = wdata[3];
      end
      if (wr_ctrl && we[1]) presc_d = wdata[15:8];
      if (wr_preset) preset_d = WIDTH'(merge_bytes(32'(preset_q), wdata, we));

      case (state_q)
        S_IDLE:  if (en_d) state_d = S_LOAD;
        S_LOAD: begin
          count_d = preset_q;
          pcnt_d  = 8'd0;
          state_d = S_COUNT;
        end
        S_COUNT: begin
          if (count_q == '0) begin
            state_d  = S_INT;
            pend_set = 1'b1;
          end else if (pcnt_q == presc_q) begin
            count_d = count_q - WIDTH'(1);
            pcnt_d  = 8'd0;
          end else begin
            pcnt_d = pcnt_q + 8'd1;
          end
        end
        S_INT:   state_d = (mode_q == 2'b01) ? S_LOAD : S_IDLE;
        default: state_d = S_IDLE;
      endcase

      if (!en_d) begin
        state_d  = S_IDLE;
        count_d  = count_q;
        pcnt_d   = pcnt_q;
        pend_set = 1'b0;
      end

      // Hardware set wins over a same-cycle W1C
      if (wr_ctrl && we[0] && wdata[4]) pend_d = 1'b0;
      if (pend_set) pend_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q  <= S_IDLE;
        en_q     <= 1'b0;
        mode_q   <= 2'b00;
        im_q     <= 1'b0;
        pend_q   <= 1'b0;
        presc_q  <= 8'd0;
        pcnt_q   <= 8'd0;
        preset_q <= '0;
        count_q  <= '0;
      end else begin
        state_q  <= state_d;
        en_q     <= en_d;
        mode_q   <= mode_d;
        im_q     <= im_d;
        pend_q   <= pend_d;
        presc_q  <= presc_d;
        pcnt_q   <= pcnt_d;
        preset_q <= preset_d;
        count_q  <= count_d;
      end
    end
  end

  always_comb begin
    rdata = 32'd0;
    for (int c = 0; c < CHANNELS; c++) rdata = rdata | rd_ch[c];
  end
endmodule

// File: tb/tb_timer_bank.sv
// tb/tb_timer_bank.sv - self-checking bench for timer_bank
// Register vector table, directed corner sequences, randomized multi-channel runs vs timing model.
module tb_timer_bank;
  localparam int          CH   = 3;
  localparam int          W    = 16;
  localparam logic [31:0] BASE = 32'h0000_7F00;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   addr, wdata, rdata;
  logic [3:0]    we;
  logic [CH-1:0] irq;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic [31:0] raddr;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    int k;
    int p;
    int s;
    int mode;
    int im;
  } cfg_t;

  cfg_t cfg [CH];
  vec_t vecs [14];

  timer_bank #(.CHANNELS(CH), .WIDTH(W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we),
    .rdata(rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  task automatic tick_to(input int t);
    while (edge_n < t) tick();
  endtask

  function automatic logic [31:0] reg_a(input int c, input int off);
    return BASE + 32'(16 * c + off);
  endfunction

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    addr  = a;
    wdata = d;
    we    = be;
    tick();
    we = 4'd0;
  endtask

  task automatic chk_rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    we   = 4'd0;
    #1;
    check(name, rdata, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Timing model from the enable edge: LOAD, COUNT for P*(s+1)+1 cycles, INT; period P*(s+1)+3
  function automatic void model(input cfg_t c, input int e, output int cnt, output int ctrl);
    int t, ph, pend, en;
    cnt  = 0;
    ctrl = 0;
    if (e >= 0) begin
      t    = c.p * (c.s + 1) + 3;
      en   = (c.mode != 1 && e >= t) ? 0 : 1;
      pend = (e >= t - 1) ? 1 : 0;
      ph   = (c.mode == 1) ? (e % t) : e;
      if (ph >= 1 && ph <= t - 2) cnt = c.p - (ph - 1) / (c.s + 1);
      ctrl = (c.s << 8) | (pend << 4) | (c.im << 3) | (c.mode << 1) | en;
    end
  endfunction

  task automatic run_trial(input int cycles);
    int cnt, ctrl, e;
    logic [CH-1:0] exp_irq;
    do_reset();
    for (int c = 0; c < CH; c++) wr(reg_a(c, 4), 32'(cfg[c].p), 4'hF);
    for (int c = 0; c < CH; c++) begin
      wr(reg_a(c, 0), 32'((cfg[c].s << 8) | (cfg[c].im << 3) | (cfg[c].mode << 1) | 1), 4'b0011);
      cfg[c].k = edge_n;
    end
    repeat (cycles) begin
      tick();
      exp_irq = '0;
      for (int c = 0; c < CH; c++) begin
        e = edge_n - cfg[c].k;
        model(cfg[c], e, cnt, ctrl);
        chk_rd($sformatf("ch%0d count e=%0d", c, e), reg_a(c, 8), 32'(cnt));
        chk_rd($sformatf("ch%0d ctrl e=%0d", c, e), reg_a(c, 0), 32'(ctrl));
        exp_irq[c] = ctrl[4] & ctrl[3];
      end
      check($sformatf("irq e0=%0d", edge_n - cfg[0].k), 32'(irq), 32'(exp_irq));
    end
  endtask

  initial begin
    int k;
    reset = 1'b1;
    addr  = 32'd0;
    wdata = 32'd0;
    we    = 4'd0;
    tick();
    check("reset irq", 32'(irq), 32'd0);
    chk_rd("reset ctrl0", reg_a(0, 0), 32'd0);
    tick();
    reset = 1'b0;

    // Register access table: byte enables, width masking, read-only and unmapped slots
    vecs[0]  = '{32'h7F04, 32'hAABBCCDD, 4'b0011, 32'h7F04, 32'h0000CCDD};
    vecs[1]  = '{32'h7F04, 32'h11223344, 4'b0100, 32'h7F04, 32'h0000CCDD};
    vecs[2]  = '{32'h7F04, 32'h11223344, 4'b0010, 32'h7F04, 32'h000033DD};
    vecs[3]  = '{32'h7F08, 32'h12345678, 4'b1111, 32'h7F08, 32'h00000000};
    vecs[4]  = '{32'h7F0C, 32'hFFFFFFFF, 4'b1111, 32'h7F0C, 32'h00000000};
    vecs[5]  = '{32'h7F00, 32'h0000AB0E, 4'b0011, 32'h7F00, 32'h0000AB0E};
    vecs[6]  = '{32'h7F00, 32'hFFFFFFFE, 4'b0001, 32'h7F00, 32'h0000AB0E};
    vecs[7]  = '{32'h7F00, 32'h00000000, 4'b0010, 32'h7F00, 32'h0000000E};
    vecs[8]  = '{32'h7F14, 32'hDEADBEEF, 4'b1111, 32'h7F14, 32'h0000BEEF};
    vecs[9]  = '{32'h7F14, 32'h00000000, 4'b0000, 32'h7F14, 32'h0000BEEF};
    vecs[10] = '{32'h7F30, 32'hFFFFFFFF, 4'b1111, 32'h7F30, 32'h00000000};
    vecs[11] = '{32'h7F24, 32'h00000100, 4'b1111, 32'h7F24, 32'h00000100};
    vecs[12] = '{32'h0000, 32'h00000000, 4'b0000, 32'h7EFC, 32'h00000000};
    vecs[13] = '{32'h0000, 32'h00000000, 4'b0000, 32'h7F04, 32'h000033DD};
    for (int v = 0; v < 14; v++) begin
      if (vecs[v].we != 4'd0) wr(vecs[v].waddr, vecs[v].wdata, vecs[v].we);
      chk_rd($sformatf("vec%0d", v), vecs[v].raddr, vecs[v].exp);
    end

    // Reset in the middle of a count
    do_reset();
    wr(reg_a(0, 4), 32'd5, 4'hF);
    wr(reg_a(0, 0), 32'h1, 4'b0001);
    k = edge_n;
    tick_to(k + 3);
    reset = 1'b1;
    for (int c = 0; c < CH; c++)
      for (int o = 0; o < 12; o += 4)
        chk_rd($sformatf("rst ch%0d off%0d", c, o), reg_a(c, o), 32'd0);
    check("rst irq", 32'(irq), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    repeat (10) tick();
    chk_rd("post-rst count", reg_a(0, 8), 32'd0);
    chk_rd("post-rst ctrl", reg_a(0, 0), 32'd0);
    check("post-rst irq", 32'(irq), 32'd0);

    // One-shot with interrupt mask open
    wr(reg_a(0, 4), 32'd4, 4'hF);
    wr(reg_a(0, 0), 32'h09, 4'b0001);
    k = edge_n;
    for (int j = 1; j <= 5; j++) begin
      tick();
      chk_rd($sformatf("oneshot count e=%0d", j), reg_a(0, 8), 32'(5 - j));
    end
    check("oneshot irq e5", 32'(irq[0]), 32'd0);
    tick();
    check("oneshot irq e6", 32'(irq[0]), 32'd1);
    chk_rd("oneshot ctrl e6", reg_a(0, 0), 32'h19);
    tick();
    chk_rd("oneshot ctrl e7", reg_a(0, 0), 32'h18);
    wr(reg_a(0, 0), 32'h10, 4'b0001);
    check("oneshot w1c irq", 32'(irq[0]), 32'd0);
    chk_rd("oneshot w1c ctrl", reg_a(0, 0), 32'h00);

    // Auto-reload with prescaler 1: INT every 7 cycles, W1C collision keeps PEND
    do_reset();
    wr(reg_a(0, 4), 32'd2, 4'hF);
    wr(reg_a(0, 0), 32'h10B, 4'b0011);
    k = edge_n;
    tick_to(k + 5);
    chk_rd("auto ctrl e5", reg_a(0, 0), 32'h10B);
    chk_rd("auto count e5", reg_a(0, 8), 32'd0);
    tick();
    chk_rd("auto ctrl e6", reg_a(0, 0), 32'h11B);
    check("auto irq e6", 32'(irq[0]), 32'd1);
    tick_to(k + 7);
    wr(reg_a(0, 0), 32'h1B, 4'b0001);
    chk_rd("auto w1c e8", reg_a(0, 0), 32'h10B);
    check("auto irq e8", 32'(irq[0]), 32'd0);
    tick_to(k + 12);
    chk_rd("auto ctrl e12", reg_a(0, 0), 32'h10B);
    tick();
    chk_rd("auto ctrl e13", reg_a(0, 0), 32'h11B);
    tick_to(k + 16);
    chk_rd("auto count e16", reg_a(0, 8), 32'd2);
    tick();
    chk_rd("auto count e17", reg_a(0, 8), 32'd1);
    tick_to(k + 19);
    wr(reg_a(0, 0), 32'h1B, 4'b0001);
    chk_rd("auto collide e20", reg_a(0, 0), 32'h11B);
    tick();
    chk_rd("auto collide e21", reg_a(0, 0), 32'h11B);

    // Three channels, channel 1 masked, then randomized configurations
    cfg[0] = '{0, 3, 0, 0, 1};
    cfg[1] = '{0, 1, 0, 0, 0};
    cfg[2] = '{0, 5, 0, 0, 1};
    run_trial(14);
    for (int t = 0; t < 8; t++) begin
      for (int c = 0; c < CH; c++) begin
        cfg[c].p    = $urandom_range(0, 6);
        cfg[c].s    = $urandom_range(0, 3);
        cfg[c].mode = $urandom_range(0, 3);
        cfg[c].im   = $urandom_range(0, 1);
      end
      run_trial(40);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
